instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache between the `cpu` instruction fetch (`PC` → `INSTRUCTION`) and the 128-bit-wide instruction memory.
- Returns the 32-bit instruction for `PC` on a hit.
- On a miss, asserts `BUSYWAIT` so the CPU holds `PC`, fetches the full 16-byte block from memory, installs it, then serves the instruction.

---
 rtl/instruction_cache_pkg.sv | 37 +++
 rtl/instruction_cache_if.sv | 36 +++
 rtl/icache_fsm.sv | 72 +++++++
 rtl/instruction_cache.sv | 82 ++++++++
 tb/tb_instruction_cache.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Holds the geometry (line count, address width, field positions), the
// fill FSM state encoding and a helper that selects one 32-bit word
// from a 128-bit line.
package instruction_cache_pkg;

  localparam int NUM_BLOCKS      = 8;
  localparam int ADDR_BITS       = 10;
  localparam int INDEX_BITS      = $clog2(NUM_BLOCKS);
  localparam int TAG_BITS        = ADDR_BITS - 4 - INDEX_BITS;
  localparam int BLOCK_ADDR_BITS = TAG_BITS + INDEX_BITS;
  localparam int WORD_BITS       = 32;
  localparam int BLOCK_BITS      = 128;

  // Field positions inside ADDRESS: [9:7] tag, [6:4] index, [3:2] word offset.
  localparam int OFFSET_LSB = 2;
  localparam int OFFSET_MSB = 3;
  localparam int INDEX_LSB  = 4;
  localparam int INDEX_MSB  = INDEX_LSB + INDEX_BITS - 1;
  localparam int TAG_LSB    = INDEX_MSB + 1;
  localparam int TAG_MSB    = ADDR_BITS - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    MEM_RD = 2'b01,
    UPDATE = 2'b10
  } icache_state_t;

  // Word 0 sits in the least significant 32 bits of the line.
  function automatic logic [WORD_BITS-1:0] select_word(
    input logic [BLOCK_BITS-1:0] block,
    input logic [1:0]            offset
  );
    return block[{offset, 5'b00000} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/instruction_cache_if.sv
// Bus bundle for the instruction cache: CPU fetch side (ADDRESS,
// INSTRUCTION, BUSYWAIT) and instruction-memory side (MEM_READ,
// MEM_ADDRESS, MEM_READDATA, MEM_BUSYWAIT).
// slave  : the cache's view.
// master : the environment's view (CPU plus instruction memory).
interface instruction_cache_if;
  import instruction_cache_pkg::*;

  logic [31:0]                  ADDRESS;
  logic [WORD_BITS-1:0]         INSTRUCTION;
  logic                         BUSYWAIT;
  logic                         MEM_READ;
  logic [BLOCK_ADDR_BITS-1:0]   MEM_ADDRESS;
  logic [BLOCK_BITS-1:0]        MEM_READDATA;
  logic                         MEM_BUSYWAIT;

  modport slave (
    input  ADDRESS,
    output INSTRUCTION,
    output BUSYWAIT,
    output MEM_READ,
    output MEM_ADDRESS,
    input  MEM_READDATA,
    input  MEM_BUSYWAIT
  );

  modport master (
    output ADDRESS,
    input  INSTRUCTION,
    input  BUSYWAIT,
    input  MEM_READ,
    input  MEM_ADDRESS,
    output MEM_READDATA,
    output MEM_BUSYWAIT
  );
endinterface

// File: rtl/icache_fsm.sv
// Refill controller for the instruction cache.
// Ports: clk/rst (async active-high), hit (lookup result for the current
// address), miss_block ({tag, index} of the current address),
// mem_busywait (memory busy). Outputs: busywait (CPU stall), mem_read,
// mem_address (latched block address of the fill), capture (load the
// returned line this edge), write_line (install the captured line this edge).
module icache_fsm
  import instruction_cache_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hit,
  input  logic [BLOCK_ADDR_BITS-1:0] miss_block,
  input  logic                       mem_busywait,
  output logic                       busywait,
  output logic                       mem_read,
  output logic [BLOCK_ADDR_BITS-1:0] mem_address,
  output logic                       capture,
  output logic                       write_line
);

  icache_state_t              state_reg, state_next;
  logic [BLOCK_ADDR_BITS-1:0] mem_address_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      mem_address_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Latch the missing block on the way into MEM_RD so a wandering
      // ADDRESS cannot disturb the request.
      if (state_reg == IDLE && !hit) begin
        mem_address_reg <= miss_block;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    busywait   = 1'b0;
    mem_read   = 1'b0;
    capture    = 1'b0;
    write_line = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (!hit) begin
          // Every line is invalid while reset is held, so mask the stall.
          busywait   = !rst;
          state_next = MEM_RD;
        end
      end
      MEM_RD: begin
        busywait = 1'b1;
        mem_read = 1'b1;
        if (!mem_busywait) begin
          capture    = 1'b1;
          state_next = UPDATE;
        end
      end
      UPDATE: begin
        busywait   = 1'b1;
        write_line = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign mem_address = mem_address_reg;

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped, read-only instruction cache: 8 lines of 16 bytes.
// Ports: CLK, RESET (async active-high) and the slave side of
// instruction_cache_if (CPU fetch plus 128-bit instruction-memory bus).
// Hits are served combinationally; misses stall the CPU via BUSYWAIT
// while icache_fsm fetches and installs the whole line.
module instruction_cache
  import instruction_cache_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RESET,
  instruction_cache_if.slave   bus
);

  logic [TAG_BITS-1:0]        tag;
  logic [INDEX_BITS-1:0]      index;
  logic [1:0]                 offset;
  logic                       unused_addr_bits;

  logic [BLOCK_BITS-1:0]      data_array [NUM_BLOCKS];
  logic [TAG_BITS-1:0]        tag_array  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0]      valid_reg;
  logic [BLOCK_BITS-1:0]      fill_data_reg;

  logic                       hit;
  logic                       capture;
  logic                       write_line;
  logic [BLOCK_ADDR_BITS-1:0] fill_block;
  logic [TAG_BITS-1:0]        fill_tag;
  logic [INDEX_BITS-1:0]      fill_index;

  assign tag    = bus.ADDRESS[TAG_MSB:TAG_LSB];
  assign index  = bus.ADDRESS[INDEX_MSB:INDEX_LSB];
  assign offset = bus.ADDRESS[OFFSET_MSB:OFFSET_LSB];
  assign unused_addr_bits = ^{bus.ADDRESS[31:ADDR_BITS], bus.ADDRESS[OFFSET_LSB-1:0]};

  assign hit = valid_reg[index] && (tag_array[index] == tag);

  icache_fsm u_fsm (
    .clk          (CLK),
    .rst          (RESET),
    .hit          (hit),
    .miss_block   ({tag, index}),
    .mem_busywait (bus.MEM_BUSYWAIT),
    .busywait     (bus.BUSYWAIT),
    .mem_read     (bus.MEM_READ),
    .mem_address  (fill_block),
    .capture      (capture),
    .write_line   (write_line)
  );

  assign bus.MEM_ADDRESS = fill_block;
  assign fill_tag        = fill_block[BLOCK_ADDR_BITS-1:INDEX_BITS];
  assign fill_index      = fill_block[INDEX_BITS-1:0];

  // Valid bits are the only storage that reset touches; an abandoned
  // fill never reaches UPDATE, so its data is simply never installed.
  for (genvar gi = 0; gi < NUM_BLOCKS; gi++) begin : g_valid
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        valid_reg[gi] <= 1'b0;
      end else if (write_line && fill_index == INDEX_BITS'(gi)) begin
        valid_reg[gi] <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (capture) begin
      fill_data_reg <= bus.MEM_READDATA;
    end
  end

  always_ff @(posedge CLK) begin
    if (write_line) begin
      data_array[fill_index] <= fill_data_reg;
      tag_array[fill_index]  <= fill_tag;
    end
  end

  assign bus.INSTRUCTION = select_word(data_array[index], offset);

endmodule

// File: tb/tb_instruction_cache.sv
// Directed testbench for instruction_cache with a behavioural memory,
// a tag-presence model and a per-cycle compare process.
module tb_instruction_cache;

  logic CLK;
  logic RESET;
  instruction_cache_if bus ();

  instruction_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int compared   = 0;
  int mismatched = 0;
  int mem_lat    = 4;
  int mem_cnt    = 0;
  bit started    = 0;

  bit         m_valid [8];
  logic [2:0] m_tag   [8];
  logic [5:0] last_fill;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Instruction memory image: word at word address w is 0xC0DE00ww.
  function automatic logic [31:0] mem_word(input logic [7:0] waddr);
    return 32'hC0DE_0000 | {24'b0, waddr};
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] b);
    logic [127:0] blk;
    for (int w = 0; w < 4; w++) blk[w*32 +: 32] = mem_word({b, 2'(w)});
    return blk;
  endfunction

  // Memory stays busy for mem_lat-1 cycles of a read, then drops, so each
  // read request lasts exactly mem_lat cycles.
  always @(posedge CLK) begin
    if (!bus.MEM_READ) mem_cnt <= 0;
    else               mem_cnt <= mem_cnt + 1;
  end
  assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt < mem_lat - 1);
  assign bus.MEM_READDATA = mem_block(bus.MEM_ADDRESS);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: a non-stalled fetch must return memory's word for the
  // address, and a pending read must target the CPU's current block.
  always @(negedge CLK) begin
    if (started && !RESET) begin
      if (bus.BUSYWAIT === 1'b0) begin
        check("cyc_instr", bus.INSTRUCTION, mem_word(bus.ADDRESS[9:2]));
        check("cyc_no_read", {31'b0, bus.MEM_READ}, 32'd0);
      end
      if (bus.MEM_READ === 1'b1)
        check("cyc_mem_addr", {26'b0, bus.MEM_ADDRESS}, {26'b0, bus.ADDRESS[9:4]});
    end
  end

  // Called at posedge+#1; returns at posedge+#1 after the CPU may advance.
  task automatic access(input logic [9:0] a, input int lat, input string name);
    bit         exp_miss;
    int         stall;
    int         rd;
    logic [2:0] ix;
    ix       = a[6:4];
    exp_miss = !(m_valid[ix] && m_tag[ix] == a[9:7]);
    bus.ADDRESS = {22'b0, a};
    mem_lat     = lat;
    @(negedge CLK);
    check({name, "_busy_first"}, {31'b0, bus.BUSYWAIT}, {31'b0, exp_miss});
    stall = 0;
    rd    = 0;
    while (bus.BUSYWAIT === 1'b1 && stall < 200) begin
      stall++;
      if (bus.MEM_READ === 1'b1) begin
        rd++;
        last_fill = bus.MEM_ADDRESS;
      end
      @(negedge CLK);
    end
    check({name, "_stall"}, stall, exp_miss ? lat + 2 : 0);
    check({name, "_read_cycles"}, rd, exp_miss ? lat : 0);
    if (exp_miss) begin
      m_valid[ix] = 1'b1;
      m_tag[ix]   = a[9:7];
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
  endtask

  initial begin
    int guard;
    clear_model();
    last_fill   = '0;
    RESET       = 1'b1;
    bus.ADDRESS = 32'h0;
    repeat (2) @(posedge CLK);
    #1;
    check("reset_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);
    check("reset_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
    check("reset_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'd0);
    RESET   = 1'b0;
    started = 1;

    // 1. Cold start: 40-cycle memory -> 42 stall cycles.
    last_fill = 6'h3F;
    access(10'h000, 40, "cold");
    check("cold_fill_addr", {26'b0, last_fill}, 32'h00);
    check("cold_instr", bus.INSTRUCTION, 32'hC0DE_0000);

    // 2. Sequential hits inside the same line.
    access(10'h004, 40, "seq4");
    check("seq4_instr", bus.INSTRUCTION, 32'hC0DE_0001);
    access(10'h008, 40, "seq8");
    check("seq8_instr", bus.INSTRUCTION, 32'hC0DE_0002);
    access(10'h00C, 40, "seq12");
    check("seq12_instr", bus.INSTRUCTION, 32'hC0DE_0003);

    // 3. Conflict on index 0.
    access(10'h080, 5, "conf80");
    check("conf80_fill_addr", {26'b0, last_fill}, 32'h08);
    check("conf80_instr", bus.INSTRUCTION, 32'hC0DE_0020);
    access(10'h000, 5, "conf00");
    check("conf00_instr", bus.INSTRUCTION, 32'hC0DE_0000);

    // 4. Long stall at 0x010 (45 stall cycles).
    access(10'h010, 43, "stall10");
    check("stall10_instr", bus.INSTRUCTION, 32'hC0DE_0004);

    // 5a. Reset 10 cycles into MEM_RD.
    bus.ADDRESS = 32'h020;
    mem_lat     = 40;
    guard       = 0;
    while (bus.MEM_READ !== 1'b1 && guard < 10) begin
      @(negedge CLK);
      guard++;
    end
    check("rst_fill_started", {31'b0, bus.MEM_READ}, 32'd1);
    repeat (10) @(posedge CLK);
    #1;
    RESET = 1'b1;
    #1;
    check("rst_mid_mem_read", {31'b0, bus.MEM_READ}, 32'd0);
    check("rst_mid_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);
    check("rst_mid_mem_addr", {26'b0, bus.MEM_ADDRESS}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model();
    access(10'h020, 6, "rst_reaccess");
    check("rst_reaccess_instr", bus.INSTRUCTION, 32'hC0DE_0008);
    access(10'h000, 6, "rst_cleared0");
    check("rst_cleared0_instr", bus.INSTRUCTION, 32'hC0DE_0000);

    // 5b. Reset on the very edge where memory completes: nothing installed.
    bus.ADDRESS = 32'h030;
    mem_lat     = 3;
    guard       = 0;
    @(negedge CLK);
    while (!(bus.MEM_READ === 1'b1 && bus.MEM_BUSYWAIT === 1'b0) && guard < 20) begin
      @(negedge CLK);
      guard++;
    end
    check("edge_reached", guard < 20 ? 32'd1 : 32'd0, 32'd1);
    RESET = 1'b1;
    #1;
    check("edge_busywait", {31'b0, bus.BUSYWAIT}, 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
    clear_model();
    access(10'h030, 3, "edge_reaccess");
    check("edge_reaccess_instr", bus.INSTRUCTION, 32'hC0DE_000C);

    // 6. Cached loop, then a taken branch to 0x3F0.
    access(10'h000, 4, "loop0");
    access(10'h004, 4, "loop4");
    access(10'h008, 4, "loop8");
    access(10'h3F0, 4, "branch");
    check("branch_fill_addr", {26'b0, last_fill}, 32'h3F);
    check("branch_instr", bus.INSTRUCTION, 32'hC0DE_00FC);
    access(10'h3F4, 4, "branch_next");
    check("branch_next_instr", bus.INSTRUCTION, 32'hC0DE_00FD);
    access(10'h00C, 4, "loop_back");
    check("loop_back_instr", bus.INSTRUCTION, 32'hC0DE_0003);

    started = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
